// File: rtl/ifmap_pkg.sv
// Shared types and defaults for the ifmap input path.
// No logic; chaining state encoding and width helpers only.
// No flow control of its own.
package ifmap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } chain_state_t;

    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_MAX_COUNT = 4;

    function automatic int chain_out_width(input int in_width, input int max_count);
        return in_width * max_count;
    endfunction

endpackage

// File: rtl/chain_counter.sv
// Chain position counter with a saturated, never-zero chain length register.
// Registered count; terminal flag is combinational from the current count.
// No flow control; inc is ignored once the count reaches MAX_COUNT.
module chain_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 terminal
);

    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_COUNT);

    logic [CNT_WIDTH-1:0] cfg_q;
    logic [CNT_WIDTH-1:0] load_sat;

    // A zero-length chain would never terminate, so it is treated as one word.
    always_comb begin
        load_sat = load_val;
        if (load_val == '0) begin
            load_sat = CNT_WIDTH'(1);
        end else if (load_val > MAX_C) begin
            load_sat = MAX_C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            cfg_q <= MAX_C;
        end else if (load) begin
            cfg_q <= load_sat;
            cnt   <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_C)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign terminal = (cnt == (cfg_q - CNT_WIDTH'(1)));

endmodule

// File: rtl/ifmap_input_chaining.sv
// Packs cfg narrow ifmap words into one wide word for the write-address generator.
// out_valid pulses one cycle after the last accept; out_data holds until the next chain.
// in_ready drops once a chain is complete until the FSM clears it with rst_n_chaining.
module ifmap_input_chaining
    import ifmap_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int MAX_COUNT = DEF_MAX_COUNT,
    parameter int CNT_WIDTH = 3,
    localparam int OUT_WIDTH = chain_out_width(IN_WIDTH, MAX_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rst_n_chaining,
    input  logic                 config_enable,
    input  logic [CNT_WIDTH-1:0] config_count,
    input  logic                 en_input_chaining,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 chaining_last_one
);

    chain_state_t state_q, state_d;

    logic [CNT_WIDTH-1:0] cnt;
    logic                 terminal;
    logic                 accept;
    logic                 complete;
    logic [OUT_WIDTH-1:0] pack_q;
    logic [OUT_WIDTH-1:0] pack_merge;

    assign accept            = in_valid && in_ready;
    assign chaining_last_one = accept && terminal;
    // A concurrent chain clear or reconfigure discards the word, so no pulse.
    assign complete          = chaining_last_one && rst_n_chaining && !config_enable;

    chain_counter #(
        .MAX_COUNT (MAX_COUNT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_chain_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!rst_n_chaining),
        .load     (config_enable),
        .load_val (config_count),
        .inc      (accept),
        .cnt      (cnt),
        .terminal (terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (config_enable) state_d = FILL;
            end
            FILL: begin
                if (complete) state_d = DONE;
            end
            DONE: begin
                if (config_enable || !rst_n_chaining) state_d = FILL;
            end
            default: state_d = IDLE;
        endcase
        if (config_enable) state_d = FILL;
    end

    always_comb begin
        in_ready = (state_q == FILL) && en_input_chaining;
    end

    always_comb begin
        pack_merge = pack_q;
        for (int i = 0; i < MAX_COUNT; i++) begin
            if (cnt == CNT_WIDTH'(i)) begin
                pack_merge[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
        end else if (config_enable || !rst_n_chaining) begin
            pack_q <= '0;
        end else if (accept) begin
            pack_q <= pack_merge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= complete;
            if (complete) begin
                out_data <= pack_merge;
            end
        end
    end

endmodule

// File: tb/tb_ifmap_input_chaining.sv
// Directed vector bench for ifmap_input_chaining: one table row per clock cycle,
// plus a hand-written asynchronous reset sequence.
module tb_ifmap_input_chaining;

    logic        clk;
    logic        rst_n;
    logic        rst_n_chaining;
    logic        config_enable;
    logic [2:0]  config_count;
    logic        en_input_chaining;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        chaining_last_one;

    int tests = 0;
    int fails = 0;

    ifmap_input_chaining dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rst_n_chaining    (rst_n_chaining),
        .config_enable     (config_enable),
        .config_count      (config_count),
        .en_input_chaining (en_input_chaining),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .chaining_last_one (chaining_last_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_ch;
        logic        cfg_en;
        logic [2:0]  cfg_cnt;
        logic        en;
        logic        vld;
        logic [15:0] dat;
        logic        e_rdy;
        logic        e_last;
        logic        e_ov;
        logic [63:0] e_od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_ch, logic cfg_en, logic [2:0] cfg_cnt, logic en,
                                logic vld, logic [15:0] dat, logic e_rdy, logic e_last,
                                logic e_ov, logic [63:0] e_od);
        vec_t v;
        v.rst_ch = rst_ch; v.cfg_en = cfg_en; v.cfg_cnt = cfg_cnt; v.en = en;
        v.vld = vld; v.dat = dat; v.e_rdy = e_rdy; v.e_last = e_last;
        v.e_ov = e_ov; v.e_od = e_od;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_ch, input logic cfg_en, input logic [2:0] cfg_cnt,
                         input logic en, input logic vld, input logic [15:0] dat);
        @(posedge clk);
        #1;
        rst_n_chaining    = rst_ch;
        config_enable     = cfg_en;
        config_count      = cfg_cnt;
        en_input_chaining = en;
        in_valid          = vld;
        in_data           = dat;
        @(negedge clk);
    endtask

    localparam logic [63:0] C4 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] C2 = 64'h0000_0000_BBBB_AAAA;
    localparam logic [63:0] C1A = 64'h0000_0000_0000_0101;
    localparam logic [63:0] C1B = 64'h0000_0000_0000_0202;
    localparam logic [63:0] CE = 64'hA004_A003_A002_A001;

    initial begin
        rst_n = 1'b0;
        rst_n_chaining = 1'b1;
        config_enable = 1'b0;
        config_count = 3'd0;
        en_input_chaining = 1'b0;
        in_data = 16'h0;
        in_valid = 1'b0;

        // rst_ch cfg_en cnt en vld dat | rdy last ov od
        vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 64'h0));
        vecs.push_back(mk(1, 1, 4, 1, 0, 16'h0000, 0, 0, 0, 64'h0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h1111, 1, 0, 0, 64'h0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h2222, 1, 0, 0, 64'h0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h3333, 1, 0, 0, 64'h0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h4444, 1, 1, 0, 64'h0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h5555, 0, 0, 1, C4));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h5555, 0, 0, 0, C4));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h5555, 1, 0, 0, C4));
        vecs.push_back(mk(1, 1, 2, 1, 0, 16'h0000, 1, 0, 0, C4));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'hAAAA, 1, 0, 0, C4));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'hBBBB, 1, 1, 0, C4));
        vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 0, 1, C2));
        vecs.push_back(mk(0, 1, 0, 1, 0, 16'h0000, 0, 0, 0, C2));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h0101, 1, 1, 0, C2));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0202, 0, 0, 1, C1A));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'h0202, 1, 1, 0, C1A));
        vecs.push_back(mk(1, 1, 7, 1, 0, 16'h0000, 0, 0, 1, C1B));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'hA001, 1, 0, 0, C1B));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'hA002, 1, 0, 0, C1B));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 16'hA003, 0, 0, 0, C1B));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'hA003, 1, 0, 0, C1B));
        vecs.push_back(mk(1, 0, 0, 1, 1, 16'hA004, 1, 1, 0, C1B));
        vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 0, 1, CE));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'h0);
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset out_data", out_data, 64'h0);
        chk("reset last_one", 64'(chaining_last_one), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst_ch, vecs[i].cfg_en, vecs[i].cfg_cnt, vecs[i].en,
                  vecs[i].vld, vecs[i].dat);
            chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("row%0d last_one", i), 64'(chaining_last_one), 64'(vecs[i].e_last));
            chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("row%0d out_data", i), out_data, vecs[i].e_od);
        end

        // Asynchronous reset in the middle of a 4-word chain (cnt==2).
        drive(1, 1, 4, 1, 0, 16'h0000);
        drive(1, 0, 0, 1, 1, 16'hC001);
        drive(1, 0, 0, 1, 1, 16'hC002);
        @(posedge clk);
        #1 in_data = 16'hC003;
        #2 rst_n = 1'b0;
        #1;
        chk("arst in_ready", 64'(in_ready), 64'h0);
        chk("arst last_one", 64'(chaining_last_one), 64'h0);
        chk("arst out_valid", 64'(out_valid), 64'h0);
        chk("arst out_data", out_data, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 1, 16'hD000 + 16'(i));
            chk($sformatf("post-arst idle%0d in_ready", i), 64'(in_ready), 64'h0);
            chk($sformatf("post-arst idle%0d out_valid", i), 64'(out_valid), 64'h0);
        end
        // Length 4 after reconfigure: last flag only on the 4th word.
        drive(1, 1, 4, 1, 0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 1, 16'hE001 + 16'(i));
            chk($sformatf("refill%0d last_one", i), 64'(chaining_last_one), 64'(i == 3));
        end
        drive(1, 0, 0, 1, 0, 16'h0000);
        chk("refill out_valid", 64'(out_valid), 64'h1);
        chk("refill out_data", out_data, 64'hE004_E003_E002_E001);
        drive(1, 0, 0, 1, 0, 16'h0000);
        chk("refill pulse width", 64'(out_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifmap_input_chaining.md
Name: ifmap_input_chaining

Overview:
- Deserializer directly upstream of the ifmap write-address generator and double buffer; controlled by the ifmap input FSM.
- Accepts narrow ifmap words over a valid/ready stream and packs a configurable number of them into one wide word.
- Flags the final narrow word with `chaining_last_one`, then presents the packed word for one cycle.
- Holds off further input until the FSM issues its synchronous chaining reset.

Parameters:
- IN_WIDTH, 16, width of one narrow input word.
- MAX_COUNT, 4, maximum number of words per chain; OUT_WIDTH = IN_WIDTH*MAX_COUNT (localparam).
- CNT_WIDTH, 3, width of the config count and internal counters; must hold MAX_COUNT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rst_n_chaining  in  1  synchronous active-low chain clear, from the FSM.
- config_enable  in  1  latch `config_count` this cycle.
- config_count  in  CNT_WIDTH  narrow words per chain.
- en_input_chaining  in  1  permit input acceptance.
- in_data  in  IN_WIDTH  narrow ifmap word.
- in_valid  in  1  `in_data` valid.
- in_ready  out  1  block accepts `in_data` this cycle.
- out_data  out  OUT_WIDTH  packed word.
- out_valid  out  1  `out_data` valid; one-cycle pulse.
- chaining_last_one  out  1  current accept is the last word of the chain.

Behaviour:
- Reset (`rst_n`=0, async) values:
  - state=IDLE, cnt=0, cfg=MAX_COUNT.
  - `out_data`=0, `out_valid`=0.
  - `in_ready`=0, `chaining_last_one`=0.
- States: IDLE, FILL, DONE.
  - IDLE -> FILL on `config_enable`.
  - FILL -> DONE on accept with cnt==cfg-1.
  - DONE -> FILL on `rst_n_chaining`=0.
  - `rst_n_chaining`=0 in IDLE leaves state in IDLE.
- Config: on `config_enable`, cfg <= `config_count`, then:
  - saturate values > MAX_COUNT to MAX_COUNT;
  - treat 0 as 1;
  - clear cnt and the packing register.
  - `config_enable` in FILL or DONE also restarts the chain and goes to FILL.
- `in_ready` = (state==FILL) && `en_input_chaining`; combinational, independent of `in_valid`.
- Accept = `in_valid` && `in_ready`. On accept, word is stored at bits [cnt*IN_WIDTH +: IN_WIDTH], then cnt++.
- First word lands at bits [IN_WIDTH-1:0]. Slices at or above cfg are zero.
- `chaining_last_one` = accept && (cnt==cfg-1); combinational, same cycle as the last accept.
- Latency: `out_valid`=1 in exactly the cycle after the last accept.
  - `out_data` is registered and stays stable until the next chain completes or a reset.
- `en_input_chaining` low mid-FILL: `in_ready`=0; partial data and cnt are held.
- DONE: `in_ready`=0. Extra `in_valid` is back-pressured, never dropped.
- `rst_n_chaining`=0 (sync, sampled at the edge):
  - cnt <= 0, packing register <= 0, DONE -> FILL.
  - `out_data` and `out_valid` already registered for the current cycle remain visible that cycle.
  - The FSM's RESET_CHAINING cycle coincides with the `out_valid` pulse, so the pulse is not lost.
- Simultaneous `config_enable` and `rst_n_chaining`=0: config wins (new cfg, cnt=0, FILL).
- Accept in the same cycle as `rst_n_chaining`=0: the clear wins and the word is discarded. The FSM never drives `en_input_chaining` in that cycle.
- cfg==1: every accept asserts `chaining_last_one`.

Decomposition:
- Shared package `ifmap_pkg`:
  - chaining state enum (IDLE/FILL/DONE);
  - IN_WIDTH and MAX_COUNT defaults;
  - OUT_WIDTH derivation.
- Sub-module `chain_counter`: a saturating counter with sync clear, load and terminal flag (cnt==cfg-1). It is reused by the write-address generator.

Test Plan:
- Reset then `config_enable` with `config_count`=4; stream 0x1111, 0x2222, 0x3333, 0x4444 with `en_input_chaining`=1 -> `chaining_last_one`=1 on the 4th accept. Next cycle `out_valid`=1 and `out_data`=0x4444_3333_2222_1111.
- After completion, hold `in_valid`=1 -> `in_ready`=0 until `rst_n_chaining`=0 for one cycle. The next chain starts cleanly and the held word is accepted first.
- `config_count`=2, stream 0xAAAA and 0xBBBB -> `out_data`=0x0000_0000_BBBB_AAAA.
- `config_count`=0 -> behaves as 1: each word pulses `chaining_last_one`.
- `config_count`=7 -> saturates to 4.
- Drop `en_input_chaining` after 2 of 4 words for 5 cycles -> `in_ready`=0 and no accepts. On re-enable, the remaining 2 words complete with correct packing.
- Assert `rst_n`=0 asynchronously mid-FILL (cnt=2) -> all outputs 0 immediately, state IDLE, cfg=4. No `out_valid` until reconfigured and refilled.
